// File: rtl/inst_fetch_pkg.sv
// Shared widths, reset fetch address and FSM encoding for the instruction-fetch front end.
package inst_fetch_pkg;

    localparam logic [31:0] DEF_INIT_PC = 32'hBFC0_0000;
    localparam int          ADDR_BUS    = 32;
    localparam int          DATA_BUS    = 32;
    localparam int          MEM_SEL_BUS = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_skid_buf.sv
// Single-entry hold slot that keeps the word decode could not accept, since the
// ROM output is lost once its enable drops.
module fetch_skid_buf #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_err,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic                  o_err
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end
    end

    // Payload is only meaningful while r_valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_data <= i_data;
            r_pc   <= i_pc;
            r_err  <= i_err;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_pc    = r_pc;
    assign o_err   = r_err;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: owns the PC, drives the ROM port and presents
// {inst, pc, valid} to decode across the ROM's one-cycle read latency.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_BUS,
    parameter int                    DATA_WIDTH = DATA_BUS,
    parameter logic [ADDR_WIDTH-1:0] INIT_PC    = DEF_INIT_PC[ADDR_WIDTH-1:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [ADDR_WIDTH-1:0]  flush_pc,
    output logic                   rom_en,
    output logic [MEM_SEL_BUS-1:0] rom_write_en,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    output logic [DATA_WIDTH-1:0]  rom_write_data,
    input  logic [DATA_WIDTH-1:0]  rom_read_data,
    output logic                   inst_valid,
    output logic [DATA_WIDTH-1:0]  inst,
    output logic [ADDR_WIDTH-1:0]  inst_pc,
    output logic                   inst_addr_err
);

    fetch_state_t          r_state;
    fetch_state_t          w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_req_pc;
    logic                  r_req_valid;
    logic                  r_req_err;
    logic                  r_halt;

    logic                  w_want;
    logic                  w_aligned;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic                  w_hold_load;
    logic                  w_hold_clear;
    logic                  w_hold_valid;
    logic [DATA_WIDTH-1:0] w_hold_data;
    logic [ADDR_WIDTH-1:0] w_hold_pc;
    logic                  w_hold_err;
    logic                  w_valid;
    logic                  w_err;

    always_comb begin
        w_state_nxt  = r_state;
        w_want       = 1'b0;
        w_hold_load  = 1'b0;
        w_hold_clear = flush;
        w_addr       = flush ? flush_pc : r_pc;
        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                w_want = flush | (~stall & ~r_halt);
                if (!flush && stall && r_req_valid && !w_hold_valid) begin
                    w_hold_load = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_want = flush | (~stall & ~r_halt);
                if (flush || !stall) begin
                    w_hold_clear = 1'b1;
                    w_state_nxt  = RUN;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    assign w_aligned  = is_aligned(w_addr[1:0]);
    assign w_addr_inc = w_addr + ADDR_WIDTH'(4);

    // A misaligned target is never sent to the ROM; it becomes an error slot and
    // fetching halts until the next redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= BOOT;
            r_pc        <= INIT_PC;
            r_req_valid <= 1'b0;
            r_req_err   <= 1'b0;
            r_halt      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_valid <= w_want;
            if (w_want) begin
                r_req_err <= ~w_aligned;
                r_halt    <= ~w_aligned;
                r_pc      <= w_aligned ? w_addr_inc : w_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_want) begin
            r_req_pc <= w_addr;
        end
    end

    fetch_skid_buf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_hold_load),
        .i_clear (w_hold_clear),
        .i_data  (rom_read_data),
        .i_pc    (r_req_pc),
        .i_err   (r_req_err),
        .o_valid (w_hold_valid),
        .o_data  (w_hold_data),
        .o_pc    (w_hold_pc),
        .o_err   (w_hold_err)
    );

    assign rom_en         = w_want & w_aligned & ~rst;
    assign rom_addr       = w_addr;
    assign rom_write_en   = '0;
    assign rom_write_data = '0;

    assign w_valid = ~rst & ~flush & (w_hold_valid | r_req_valid);
    assign w_err   = w_hold_valid ? w_hold_err : r_req_err;

    assign inst_valid    = w_valid;
    assign inst_addr_err = w_valid & w_err;
    assign inst          = (!w_valid || w_err) ? '0
                         : (w_hold_valid ? w_hold_data : rom_read_data);
    assign inst_pc       = !w_valid ? '0 : (w_hold_valid ? w_hold_pc : r_req_pc);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then random stall/flush/reset traffic,
// each cycle compared against a decode-side model of which word should be shown.
module tb_inst_fetch;

    localparam logic [31:0] BASE = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        rom_en;
    logic [3:0]  rom_write_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_write_data;
    logic [31:0] rom_read_data = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_addr_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the word decode sees this cycle, next fetch address, boot/halt flags.
    bit          m_show_v   = 1'b0;
    bit          m_show_err = 1'b0;
    logic [31:0] m_show_pc  = '0;
    logic [31:0] m_pc       = BASE;
    bit          m_boot     = 1'b0;
    bit          m_halt     = 1'b0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .rom_en         (rom_en),
        .rom_write_en   (rom_write_en),
        .rom_addr       (rom_addr),
        .rom_write_data (rom_write_data),
        .rom_read_data  (rom_read_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_addr_err  (inst_addr_err)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] w;
        case (a)
            BASE:          w = 32'h1111_1111;
            BASE + 32'd4:  w = 32'h2222_2222;
            BASE + 32'd8:  w = 32'h3333_3333;
            default:       w = {a[15:0] ^ 16'h5A3C, a[15:0]};
        endcase
        return w;
    endfunction

    always @(posedge clk) begin
        rom_read_data <= rom_en ? rom_word(rom_addr) : 32'h0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_fetch(input logic [31:0] a);
        m_show_v   = 1'b1;
        m_show_pc  = a;
        m_show_err = (a[1:0] != 2'b00);
        if (m_show_err) begin
            m_halt = 1'b1;
        end else begin
            m_halt = 1'b0;
            m_pc   = a + 32'd4;
        end
    endtask

    task automatic step(input bit r, input bit s, input bit f, input logic [31:0] fpc);
        bit          exp_v;
        bit          exp_en;
        logic [31:0] exp_addr;
        @(negedge clk);
        rst = r;
        stall = s;
        flush = f;
        flush_pc = fpc;
        #1;
        exp_v    = !r && !f && m_show_v;
        exp_en   = !r && !m_boot && (f ? (fpc[1:0] == 2'b00) : (!s && !m_halt));
        exp_addr = f ? fpc : m_pc;
        chk("inst_valid", 32'(inst_valid), 32'(exp_v));
        if (exp_v) begin
            chk("inst", inst, m_show_err ? 32'h0 : rom_word(m_show_pc));
            chk("inst_pc", inst_pc, m_show_pc);
            chk("inst_addr_err", 32'(inst_addr_err), 32'(m_show_err));
        end else begin
            chk("inst_addr_err_idle", 32'(inst_addr_err), 32'h0);
        end
        if (r || m_boot) begin
            chk("inst_rst", inst, 32'h0);
            chk("inst_pc_rst", inst_pc, 32'h0);
        end
        chk("rom_en", 32'(rom_en), 32'(exp_en));
        if (exp_en) chk("rom_addr", rom_addr, exp_addr);
        chk("rom_write_en", 32'(rom_write_en), 32'h0);
        chk("rom_write_data", rom_write_data, 32'h0);
        // Advance to what decode should see next cycle.
        if (r) begin
            m_show_v = 1'b0;
            m_pc     = BASE;
            m_boot   = 1'b1;
            m_halt   = 1'b0;
        end else if (m_boot) begin
            m_show_v = 1'b0;
            m_boot   = 1'b0;
        end else if (f) begin
            model_fetch(fpc);
        end else if (s) begin
            m_show_v = m_show_v;
        end else if (m_halt) begin
            m_show_v = 1'b0;
        end else begin
            model_fetch(m_pc);
        end
    endtask

    initial begin
        logic [31:0] t;
        bit          r;
        bit          s;
        bit          f;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("boot_rom_en", 32'(rom_en), 32'h0);
        step(0, 0, 0, 0);
        chk("first_addr", rom_addr, 32'hBFC0_0000);
        step(0, 0, 0, 0);
        chk("first_valid", 32'(inst_valid), 32'h1);
        chk("first_inst", inst, 32'h1111_1111);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            chk("stall_inst", inst, 32'h2222_2222);
            chk("stall_pc", inst_pc, 32'hBFC0_0004);
            chk("stall_rom_en", 32'(rom_en), 32'h0);
        end
        step(0, 0, 0, 0);
        chk("release_inst", inst, 32'h2222_2222);
        step(0, 0, 0, 0);
        chk("after_release", inst, 32'h3333_3333);

        step(0, 0, 1, 32'hBFC0_0100);
        chk("flush_cycle_valid", 32'(inst_valid), 32'h0);
        step(0, 1, 0, 0);
        chk("redirect_pc", inst_pc, 32'hBFC0_0100);
        step(0, 1, 0, 0);
        step(0, 1, 1, 32'hBFC0_0200);
        chk("hold_flush_valid", 32'(inst_valid), 32'h0);
        step(0, 0, 0, 0);
        chk("hold_flush_pc", inst_pc, 32'hBFC0_0200);

        step(0, 0, 1, 32'hBFC0_0102);
        chk("misalign_rom_en", 32'(rom_en), 32'h0);
        step(0, 0, 0, 0);
        chk("misalign_err", 32'(inst_addr_err), 32'h1);
        chk("misalign_inst", inst, 32'h0);
        chk("misalign_pc", inst_pc, 32'hBFC0_0102);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("halted_rom_en", 32'(rom_en), 32'h0);

        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("wrap_pc", inst_pc, 32'h0000_0000);

        step(0, 0, 1, 32'hBFC0_0010);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_hold_valid", 32'(inst_valid), 32'h0);
        step(0, 0, 0, 0);
        chk("rst_restart_addr", rom_addr, 32'hBFC0_0000);

        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 249) == 0);
            s = ($urandom_range(0, 9) < 3);
            f = !m_boot && ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 9))
                0: t = 32'hFFFF_FFF8;
                1, 2: begin
                    t = BASE + ($urandom_range(0, 255) << 2);
                    t[1:0] = 2'($urandom_range(1, 3));
                end
                default: t = BASE + ($urandom_range(0, 255) << 2);
            endcase
            step(r, s, f, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
